mem_dma_engine: RTL
===================

# mem_dma_engine

Single-channel memory initiator that drives the 1K×16 data memory's single port (combinational read, synchronous write) to perform block copy or block fill without CPU involvement. It sits beside the datapath on the memory port mux; while `busy` is high it owns `addr`/`writeEn`/`dataWrite`. A transfer is launched by a one-cycle `start` with source, destination, length and mode, and completion is flagged by a one-cycle `done`.

## Interface
- ADDR_W, 10, memory word-address width
- DATA_W, 16, memory word width
- LEN_W, ADDR_W+1, transfer length width (0..1024 words)
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- start  in  1  launch request, sampled only in IDLE
- mode  in  1  0 = COPY (src→dst), 1 = FILL (pattern→dst)
- src_addr  in  ADDR_W  first source word (ignored in FILL)
- dst_addr  in  ADDR_W  first destination word
- len  in  LEN_W  number of words
- pattern  in  DATA_W  fill value (ignored in COPY)
- busy  out  1  high in READ/WRITE states
- done  out  1  one-cycle completion pulse
- mem_addr  out  ADDR_W  to memory addr
- mem_we  out  1  to memory writeEn
- mem_wdata  out  DATA_W  to memory dataWrite
- mem_rdata  in  DATA_W  from memory dataRead (combinational)

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE: `start`=1 latches src, dst, len, mode, pattern into internal regs; len=0 → DONE; COPY → READ; FILL → WRITE. Otherwise stay.
- READ: mem_addr=src_ptr, mem_we=0; mem_rdata registered into data_reg at clock edge; src_ptr+1; → WRITE.
- WRITE: mem_addr=dst_ptr, mem_we=1, mem_wdata=data_reg (COPY) or pattern (FILL); dst_ptr+1, remaining−1. Remaining reaching 0 → DONE; else COPY → READ, FILL → WRITE.
- DONE: done=1, busy=0, memory outputs idle; → IDLE unconditionally.
- Idle outputs (IDLE, DONE, reset): mem_addr=0, mem_we=0, mem_wdata=0.
- Pointer arithmetic modulo 2^ADDR_W: 1023+1 wraps to 0; no error flag.
- Copy always ascending; overlapping ranges with dst>src replicate source words (defined behaviour, not an error).
- `start` outside IDLE ignored; inputs other than start are don't-care except in the start cycle.
- Reset at any time: all state to IDLE, all outputs to 0, no further writes; transfer abandoned, no done.

## Timing
- Cycle 0 = cycle in which start is sampled high in IDLE. busy=1 from cycle 1.
- COPY, len=N: READ in odd cycles 1,3,…,2N−1; WRITE in even cycles 2,…,2N; done=1 in cycle 2N+1; IDLE (new start accepted) cycle 2N+2.
- FILL, len=N: WRITE cycles 1..N; done in N+1.
- len=0: done in cycle 1, no mem_we pulse, busy never high.
- Outputs registered from state/pointers; mem_we never glitches outside WRITE.

## Structure
- Package `mem_pkg`: ADDR_W, DATA_W constants; `dma_state_t` enum (IDLE, READ, WRITE, DONE); `dma_mode_t` enum (COPY, FILL). Shared with the memory port mux.
- Single module; no sub-module required. Pointers, remaining counter and data_reg live in one always_ff; next-state/output decode in one always_comb.

## Test plan
- COPY len=2, src=8 (mem[8]=0x0001, mem[9]=0x0003), dst=16 → mem[16]=0x0001, mem[17]=0x0003; writes in cycles 2 and 4; done in cycle 5 only.
- FILL len=3, dst=0x3FE, pattern=0xBEEF → mem[0x3FE], mem[0x3FF], mem[0x000]=0xBEEF (wrap); done cycle 4.
- len=0 start → done cycle 1, mem_we never asserted, memory unchanged.
- start pulsed again in cycle 2 of a len=4 COPY → ignored; exactly 4 writes; single done.
- reset asserted in cycle 3 of COPY len=4 src=8 dst=32 → outputs 0 immediately, only mem[32] written, no done; fresh start afterwards runs normally.
- Overlap COPY src=8, dst=9, len=3, mem[8]=0x0001 → mem[9..11]=0x0001.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory port: widths and the DMA engine's
// state and mode encodings, also used by the memory port mux.
package mem_pkg;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } dma_state_t;

  typedef enum logic {
    COPY = 1'b0,
    FILL = 1'b1
  } dma_mode_t;

endpackage

// File: rtl/mem_dma_engine.sv
// Single-channel block copy/fill initiator for the 1Kx16 data memory port.
// Owns mem_addr/mem_we/mem_wdata while busy; pulses done for one cycle at the end.
module mem_dma_engine #(
  parameter int ADDR_W = mem_pkg::ADDR_W,
  parameter int DATA_W = mem_pkg::DATA_W,
  parameter int LEN_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] pattern,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        o_dbg_state
);
  import mem_pkg::*;

  // Handshake: start is a single-cycle request honoured only in IDLE; there is
  // no back-pressure, done is a one-cycle pulse the cycle before IDLE returns.

  dma_state_t        r_state;
  dma_state_t        w_next;
  dma_mode_t         r_mode;
  logic [ADDR_W-1:0] r_src_ptr;
  logic [ADDR_W-1:0] r_dst_ptr;
  logic [LEN_W-1:0]  r_remaining;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] r_pattern;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          if (len == '0)                     w_next = DONE;
          else if (dma_mode_t'(mode) == FILL) w_next = WRITE;
          else                               w_next = READ;
        end
      end
      READ:  w_next = WRITE;
      WRITE: begin
        if (r_remaining == LEN_W'(1)) w_next = DONE;
        else if (r_mode == FILL)      w_next = WRITE;
        else                          w_next = READ;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Outputs decode only registered state and pointers, so mem_we cannot glitch.
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    case (r_state)
      READ: begin
        busy     = 1'b1;
        mem_addr = r_src_ptr;
      end
      WRITE: begin
        busy      = 1'b1;
        mem_addr  = r_dst_ptr;
        mem_we    = 1'b1;
        mem_wdata = (r_mode == FILL) ? r_pattern : r_data;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign o_dbg_state = r_state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_mode      <= COPY;
      r_src_ptr   <= '0;
      r_dst_ptr   <= '0;
      r_remaining <= '0;
      r_data      <= '0;
      r_pattern   <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_mode      <= dma_mode_t'(mode);
            r_src_ptr   <= src_addr;
            r_dst_ptr   <= dst_addr;
            r_remaining <= len;
            r_pattern   <= pattern;
          end
        end
        READ: begin
          r_data    <= mem_rdata;
          r_src_ptr <= r_src_ptr + ADDR_W'(1);
        end
        WRITE: begin
          // Pointers wrap modulo 2^ADDR_W by plain overflow.
          r_dst_ptr   <= r_dst_ptr + ADDR_W'(1);
          r_remaining <= r_remaining - LEN_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
